// File: rtl/msi_pkg.sv
// Shared encodings for the MSI snooping cache controller:
// line states, bus commands and controller FSM states.
package msi_pkg;

  localparam logic [1:0] MSI_M = 2'b10;
  localparam logic [1:0] MSI_S = 2'b00;
  localparam logic [1:0] MSI_I = 2'b01;

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_RD_MISS = 2'b01;
  localparam logic [1:0] CMD_WR_MISS = 2'b10;
  localparam logic [1:0] CMD_INV     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_BUS    = 2'd2,
    ST_RESP   = 2'd3
  } msi_fsm_e;

endpackage

// File: rtl/msi_line_array.sv
// Per-line MSI state and tag storage with a CPU and a snoop port.
// Both writes may land on one index; the CPU/grant write wins.
module msi_line_array
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 6,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] cpu_idx_i,
  output logic [1:0]       cpu_state_o,
  output logic [TAG_W-1:0] cpu_tag_o,
  input  logic             cpu_we_i,
  input  logic [1:0]       cpu_wstate_i,
  input  logic [TAG_W-1:0] cpu_wtag_i,
  input  logic [IDX_W-1:0] snp_idx_i,
  output logic [1:0]       snp_state_o,
  output logic [TAG_W-1:0] snp_tag_o,
  input  logic             snp_we_i,
  input  logic [1:0]       snp_wstate_i
);

  logic [1:0]       state_q [NUM_LINES];
  logic [TAG_W-1:0] tag_q   [NUM_LINES];

  assign cpu_state_o = state_q[cpu_idx_i];
  assign cpu_tag_o   = tag_q[cpu_idx_i];
  assign snp_state_o = state_q[snp_idx_i];
  assign snp_tag_o   = tag_q[snp_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= MSI_I;
        tag_q[i]   <= '0;
      end
    end else begin
      if (snp_we_i) begin
        state_q[snp_idx_i] <= snp_wstate_i;
      end
      if (cpu_we_i) begin
        state_q[cpu_idx_i] <= cpu_wstate_i;
        tag_q[cpu_idx_i]   <= cpu_wtag_i;
      end
    end
  end

endmodule

// File: rtl/msi_snoop_ctrl.sv
// Direct-mapped, state-only MSI coherence controller: CPU requests
// go out on a req/gnt snooping bus, snoops are serviced every cycle.
module msi_snoop_ctrl
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic              bus_req,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wb,
  output logic [ADDR_W-1:0] bus_wb_addr,
  input  logic              bus_gnt,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_wb,
  output logic              snoop_abort
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  msi_fsm_e          state_q, state_d;
  logic              rdy_q;
  logic              we_q, we_d;
  logic              wb_q, wb_d;
  logic              hit_q, hit_d;
  logic              swb_q;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

  logic [IDX_W-1:0]  req_idx, snp_idx;
  logic [TAG_W-1:0]  req_tag, snp_tag;
  logic [TAG_W-1:0]  cur_tag, snp_line_tag;
  logic [1:0]        arr_state, snp_state, cur_state;
  logic [1:0]        snp_wstate, cpu_wstate;
  logic              snp_we, snp_flush, cpu_we;
  logic              gnt_acc, snp_ok, snp_hit, tag_hit;

  assign req_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:IDX_W];
  assign snp_idx = snoop_addr[IDX_W-1:0];
  assign snp_tag = snoop_addr[ADDR_W-1:IDX_W];

  msi_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W)
  ) u_arr (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_idx_i    (req_idx),
    .cpu_state_o  (arr_state),
    .cpu_tag_o    (cur_tag),
    .cpu_we_i     (cpu_we),
    .cpu_wstate_i (cpu_wstate),
    .cpu_wtag_i   (req_tag),
    .snp_idx_i    (snp_idx),
    .snp_state_o  (snp_state),
    .snp_tag_o    (snp_line_tag),
    .snp_we_i     (snp_we),
    .snp_wstate_i (snp_wstate)
  );

  // A snoop colliding with our own grant is dropped.
  assign gnt_acc = bus_gnt & (state_q == ST_BUS);
  assign snp_ok  = snoop_valid & ~gnt_acc;
  assign snp_hit = snp_ok & (snp_state != MSI_I) &
                   (snp_line_tag == snp_tag);

  always_comb begin
    snp_we     = 1'b0;
    snp_flush  = 1'b0;
    snp_wstate = snp_state;
    unique case (1'b1)
      snp_hit && snp_state == MSI_M &&
      snoop_cmd == CMD_RD_MISS: begin
        snp_we     = 1'b1;
        snp_flush  = 1'b1;
        snp_wstate = MSI_S;
      end
      snp_hit && snp_state == MSI_M &&
      snoop_cmd == CMD_WR_MISS: begin
        snp_we     = 1'b1;
        snp_flush  = 1'b1;
        snp_wstate = MSI_I;
      end
      snp_hit && snp_state == MSI_S &&
      (snoop_cmd == CMD_WR_MISS ||
       snoop_cmd == CMD_INV): begin
        snp_we     = 1'b1;
        snp_wstate = MSI_I;
      end
      default: ;
    endcase
  end

  // Lookup and collision handling see the post-snoop line state.
  assign cur_state = (snp_we && snp_idx == req_idx) ?
                     snp_wstate : arr_state;
  assign tag_hit   = (cur_state != MSI_I) && (cur_tag == req_tag);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    wb_d       = wb_q;
    wb_addr_d  = wb_addr_q;
    hit_d      = hit_q;
    cpu_we     = 1'b0;
    cpu_wstate = MSI_I;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_valid && rdy_q) begin
          we_d    = cpu_req_we;
          addr_d  = cpu_req_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (tag_hit && (!we_q || cur_state == MSI_M)) begin
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tag_hit) begin
          cmd_d   = CMD_INV;
          wb_d    = 1'b0;
          state_d = ST_BUS;
        end else begin
          cmd_d     = we_q ? CMD_WR_MISS : CMD_RD_MISS;
          wb_d      = (cur_state == MSI_M);
          wb_addr_d = {cur_tag, req_idx};
          state_d   = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_gnt) begin
          cpu_we     = 1'b1;
          cpu_wstate = (cmd_q == CMD_RD_MISS) ? MSI_S : MSI_M;
          hit_d      = (cmd_q == CMD_INV);
          state_d    = ST_RESP;
        end else begin
          if (cmd_q == CMD_INV && cur_state == MSI_I) begin
            cmd_d = CMD_WR_MISS;
          end
          if (cmd_q != CMD_INV && cur_state != MSI_M) begin
            wb_d = 1'b0;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= CMD_NONE;
      wb_q      <= 1'b0;
      wb_addr_q <= '0;
      hit_q     <= 1'b0;
      swb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= (state_d == ST_IDLE);
      we_q      <= we_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      wb_q      <= wb_d;
      wb_addr_q <= wb_addr_d;
      hit_q     <= hit_d;
      swb_q     <= snp_flush;
    end
  end

  assign cpu_req_ready  = rdy_q;
  assign cpu_resp_valid = (state_q == ST_RESP);
  assign cpu_resp_hit   = cpu_resp_valid & hit_q;
  assign bus_req        = (state_q == ST_BUS);
  assign bus_cmd        = bus_req ? cmd_q : CMD_NONE;
  assign bus_addr       = bus_req ? addr_q : '0;
  assign bus_wb         = bus_req & wb_q;
  assign bus_wb_addr    = bus_wb ? wb_addr_q : '0;
  assign snoop_wb       = swb_q;
  assign snoop_abort    = swb_q;

  a_no_snoop_on_gnt: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(snoop_valid && gnt_acc));

  a_no_inv_on_m: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(snp_hit && snp_state == MSI_M && snoop_cmd == CMD_INV));

endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// Directed bench for msi_snoop_ctrl, 4 lines x 8-bit block address.
// Drives and samples 1 time unit after each rising edge.
module tb_msi_snoop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req_valid, cpu_req_we;
  logic [7:0] cpu_req_addr;
  logic       cpu_req_ready, cpu_resp_valid, cpu_resp_hit;
  logic       bus_req, bus_wb, bus_gnt;
  logic [1:0] bus_cmd;
  logic [7:0] bus_addr, bus_wb_addr;
  logic       snoop_valid;
  logic [1:0] snoop_cmd;
  logic [7:0] snoop_addr;
  logic       snoop_wb, snoop_abort;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msi_snoop_ctrl #(.NUM_LINES(4), .ADDR_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_hit   (cpu_resp_hit),
    .bus_req        (bus_req),
    .bus_cmd        (bus_cmd),
    .bus_addr       (bus_addr),
    .bus_wb         (bus_wb),
    .bus_wb_addr    (bus_wb_addr),
    .bus_gnt        (bus_gnt),
    .snoop_valid    (snoop_valid),
    .snoop_cmd      (snoop_cmd),
    .snoop_addr     (snoop_addr),
    .snoop_wb       (snoop_wb),
    .snoop_abort    (snoop_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the controller in its LOOKUP cycle.
  task automatic cpu_req(input logic we, input logic [7:0] a);
    int n = 0;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    while (!cpu_req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready", cpu_req_ready, 1);
    tick();
    cpu_req_valid = 1'b0;
  endtask

  task automatic grant();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] c, input logic [7:0] a);
    snoop_valid = 1'b1;
    snoop_cmd   = c;
    snoop_addr  = a;
    tick();
    snoop_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    bus_gnt       = 1'b0;
    snoop_valid   = 1'b0;
    snoop_cmd     = 2'b00;
    snoop_addr    = '0;
    repeat (2) tick();
    chk("rst_ready", cpu_req_ready, 0);
    chk("rst_busreq", bus_req, 0);
    chk("rst_rv", cpu_resp_valid, 0);
    chk("rst_swb", snoop_wb, 0);
    chk("rst_l1", dut.u_arr.state_q[1], 2'b01);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", cpu_req_ready, 1);

    // 1: read miss fills S, then read hit
    cpu_req(1'b0, 8'h05);
    chk("t1_lk_rv", cpu_resp_valid, 0);
    tick();
    chk("t1_req", bus_req, 1);
    chk("t1_cmd", bus_cmd, 2'b01);
    chk("t1_addr", bus_addr, 8'h05);
    chk("t1_wb", bus_wb, 0);
    tick();
    chk("t1_hold_req", bus_req, 1);
    chk("t1_hold_cmd", bus_cmd, 2'b01);
    grant();
    chk("t1_rv", cpu_resp_valid, 1);
    chk("t1_hit", cpu_resp_hit, 0);
    chk("t1_req_off", bus_req, 0);
    chk("t1_st", dut.u_arr.state_q[1], 2'b00);
    chk("t1_tag", dut.u_arr.tag_q[1], 6'h01);
    tick();
    chk("t1_rv_off", cpu_resp_valid, 0);
    chk("t1_ready", cpu_req_ready, 1);
    cpu_req(1'b0, 8'h05);
    chk("t1h_lk_req", bus_req, 0);
    chk("t1h_lk_rv", cpu_resp_valid, 0);
    tick();
    chk("t1h_rv", cpu_resp_valid, 1);
    chk("t1h_hit", cpu_resp_hit, 1);
    chk("t1h_req", bus_req, 0);
    tick();

    // 2: upgrade S->M, then snoop read flushes it
    cpu_req(1'b1, 8'h05);
    tick();
    chk("t2_cmd", bus_cmd, 2'b11);
    chk("t2_wb", bus_wb, 0);
    grant();
    chk("t2_rv", cpu_resp_valid, 1);
    chk("t2_hit", cpu_resp_hit, 1);
    chk("t2_st", dut.u_arr.state_q[1], 2'b10);
    tick();
    snoop(2'b01, 8'h05);
    chk("t2_swb", snoop_wb, 1);
    chk("t2_abort", snoop_abort, 1);
    chk("t2_st_s", dut.u_arr.state_q[1], 2'b00);
    tick();
    chk("t2_swb_off", snoop_wb, 0);
    chk("t2_abort_off", snoop_abort, 0);
    cpu_req(1'b1, 8'h05);
    tick();
    grant();
    chk("t2_st_m", dut.u_arr.state_q[1], 2'b10);
    tick();

    // 3: read miss evicting an M victim
    cpu_req(1'b0, 8'h09);
    tick();
    chk("t3_cmd", bus_cmd, 2'b01);
    chk("t3_addr", bus_addr, 8'h09);
    chk("t3_wb", bus_wb, 1);
    chk("t3_wbaddr", bus_wb_addr, 8'h05);
    grant();
    chk("t3_hit", cpu_resp_hit, 0);
    chk("t3_st", dut.u_arr.state_q[1], 2'b00);
    chk("t3_tag", dut.u_arr.tag_q[1], 6'h02);
    tick();

    // 4: pending upgrade loses its copy to a snoop invalidate
    cpu_req(1'b0, 8'h05);
    tick();
    chk("t4_s_victim_wb", bus_wb, 0);
    grant();
    tick();
    cpu_req(1'b1, 8'h05);
    tick();
    chk("t4_cmd_inv", bus_cmd, 2'b11);
    snoop(2'b11, 8'h05);
    chk("t4_cmd_wm", bus_cmd, 2'b10);
    chk("t4_req", bus_req, 1);
    chk("t4_st_i", dut.u_arr.state_q[1], 2'b01);
    grant();
    chk("t4_rv", cpu_resp_valid, 1);
    chk("t4_hit", cpu_resp_hit, 0);
    chk("t4_st_m", dut.u_arr.state_q[1], 2'b10);
    chk("t4_tag", dut.u_arr.tag_q[1], 6'h01);
    tick();

    // 5: snoop with a tag mismatch is ignored
    snoop(2'b10, 8'h0D);
    chk("t5_swb", snoop_wb, 0);
    chk("t5_st", dut.u_arr.state_q[1], 2'b10);

    // pending victim write-back cancelled by a snoop flush
    cpu_req(1'b0, 8'h09);
    tick();
    chk("t5b_wb", bus_wb, 1);
    snoop(2'b01, 8'h05);
    chk("t5b_wb_drop", bus_wb, 0);
    chk("t5b_swb", snoop_wb, 1);
    chk("t5b_req", bus_req, 1);
    grant();
    chk("t5b_st", dut.u_arr.state_q[1], 2'b00);
    chk("t5b_tag", dut.u_arr.tag_q[1], 6'h02);
    tick();

    // 6: reset while a transaction is on the bus
    cpu_req(1'b0, 8'h0D);
    tick();
    chk("t6_req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_off", bus_req, 0);
    chk("t6_cmd_off", bus_cmd, 2'b00);
    chk("t6_addr_off", bus_addr, 8'h00);
    chk("t6_ready_off", cpu_req_ready, 0);
    chk("t6_st", dut.u_arr.state_q[1], 2'b01);
    repeat (2) tick();
    chk("t6_rv", cpu_resp_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_rv_rel", cpu_resp_valid, 0);
    chk("t6_ready", cpu_req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
